bias_add_dispatch: RTL and testbench

- Downstream consumer of the 128-to-16 bias FIFO.
- Pops one 16-bit signed bias per output channel and adds it to each conv accumulator of that channel.
- Emits biased sums to the spike/LIF stage over a valid/ready link.
- Runs one layer pass per i_start: channel-major order, i_pix_num accumulators per channel, i_ch_num channels.

---
 rtl/bias_add_dispatch_pkg.sv | 32 +++
 rtl/bias_add_dispatch_sat.sv | 31 +++
 rtl/bias_add_dispatch.sv | 161 ++++++++++++++++
 tb/tb_bias_add_dispatch.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_add_dispatch_pkg.sv
// Shared definitions for the bias-add dispatcher: FSM state encoding,
// default widths and the signed saturation helper used when the
// BIAS_SAT_EN build option is defined.
package bias_add_dispatch_pkg;

    localparam int BIAS_W_DEF = 16;
    localparam int ACC_W_DEF  = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Clamp a signed value into the range of an out_w-bit two's-complement word.
    function automatic longint sat_signed(input longint v, input int out_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (out_w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/bias_add_dispatch_sat.sv
// bias_sat_add: combinational sign-extend, add and narrow of one
// accumulator plus one bias. The sum is formed at ACC_W+1 bits so it can
// never overflow; narrowing to OUT_W either saturates (BIAS_SAT_EN defined)
// or keeps the low OUT_W bits (default, two's-complement wrap).
module bias_sat_add
    import bias_add_dispatch_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int OUT_W  = 16
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [BIAS_W-1:0] bias_i,
    output logic signed [OUT_W-1:0]  sum_o
);

    logic signed [ACC_W:0] acc_x;
    logic signed [ACC_W:0] bias_x;
    logic signed [ACC_W:0] sum_full;

    assign acc_x    = {acc_i[ACC_W-1], acc_i};
    assign bias_x   = {{(ACC_W + 1 - BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    assign sum_full = acc_x + bias_x;

`ifdef BIAS_SAT_EN
    assign sum_o = OUT_W'(sat_signed(longint'(sum_full), OUT_W));
`else
    assign sum_o = OUT_W'(sum_full);
`endif

endmodule

// File: rtl/bias_add_dispatch.sv
// bias_add_dispatch: pops one bias per output channel from the bias FIFO
// and adds it to every conv accumulator of that channel, forwarding the
// biased sums over a valid/ready link. One layer pass per i_start, in
// channel-major order. Build option BIAS_SAT_EN selects saturating
// narrowing of the sum; the default build wraps.
module bias_add_dispatch
    import bias_add_dispatch_pkg::*;
#(
    parameter int BIAS_W   = BIAS_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int OUT_W    = 16,
    parameter int CNT_W    = 12,
    parameter int FIFO_LAT = 1
) (
    input  logic                     system_clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_ch_num,
    input  logic [CNT_W-1:0]         i_pix_num,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_bias_rden,
    input  logic signed [BIAS_W-1:0] i_bias_data,
    input  logic                     i_bias_empty,
    input  logic                     i_acc_valid,
    input  logic signed [ACC_W-1:0]  i_acc_data,
    output logic                     o_acc_ready,
    output logic                     o_sum_valid,
    output logic signed [OUT_W-1:0]  o_sum_data,
    input  logic                     i_sum_ready
);

    state_t                   state_q;
    logic [CNT_W-1:0]         ch_num_q;
    logic [CNT_W-1:0]         pix_num_q;
    logic [CNT_W-1:0]         ch_cnt_q;
    logic [CNT_W-1:0]         pix_cnt_q;
    logic [CNT_W-1:0]         lat_q;
    logic signed [BIAS_W-1:0] bias_q;
    logic signed [OUT_W-1:0]  sum_q;
    logic signed [OUT_W-1:0]  sum_d;
    logic                     sum_vld_q;
    logic                     busy_q;
    logic                     done_q;

    logic acc_hs;
    logic sum_hs;
    logic last_pix;
    logic last_ch;

    // Pop and accept are combinational so a pop can never coincide with an
    // empty FIFO and the accumulator path keeps single-cycle throughput;
    // both are forced low while reset is asserted so a reset never pops.
    assign o_bias_rden = rst_n && (state_q == ST_FETCH) && !i_bias_empty;
    assign o_acc_ready = rst_n && (state_q == ST_RUN) && (!sum_vld_q || i_sum_ready);

    assign acc_hs   = i_acc_valid && o_acc_ready;
    assign sum_hs   = sum_vld_q && i_sum_ready;
    assign last_pix = (pix_cnt_q == pix_num_q - CNT_W'(1));
    assign last_ch  = (ch_cnt_q == ch_num_q - CNT_W'(1));

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_sum_valid = sum_vld_q;
    assign o_sum_data  = sum_q;

    bias_sat_add #(
        .ACC_W  (ACC_W),
        .BIAS_W (BIAS_W),
        .OUT_W  (OUT_W)
    ) u_sat_add (
        .acc_i  (i_acc_data),
        .bias_i (bias_q),
        .sum_o  (sum_d)
    );

    // Pass sequencer plus the output register of the sum link.
    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ch_num_q  <= '0;
            pix_num_q <= '0;
            ch_cnt_q  <= '0;
            pix_cnt_q <= '0;
            lat_q     <= '0;
            bias_q    <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // A new sum overwrites the register only when it is free or
            // being taken this cycle, so a stalled sum stays stable.
            if (acc_hs) begin
                sum_q     <= sum_d;
                sum_vld_q <= 1'b1;
            end else if (sum_hs) begin
                sum_vld_q <= 1'b0;
            end

            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        ch_num_q  <= i_ch_num;
                        pix_num_q <= i_pix_num;
                        ch_cnt_q  <= '0;
                        pix_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        if ((i_ch_num == '0) || (i_pix_num == '0)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!i_bias_empty) begin
                        lat_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_q == CNT_W'(FIFO_LAT - 1)) begin
                        bias_q  <= i_bias_data;
                        state_q <= ST_RUN;
                    end else begin
                        lat_q <= lat_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (acc_hs) begin
                        if (last_pix) begin
                            pix_cnt_q <= '0;
                            ch_cnt_q  <= ch_cnt_q + CNT_W'(1);
                            state_q   <= last_ch ? ST_DRAIN : ST_FETCH;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!sum_vld_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_add_dispatch.sv
// Testbench for bias_add_dispatch: table-driven single-sum vectors,
// directed multi-cycle sequences and randomized passes checked against
// a queue-based reference model of the pass.
module tb_bias_add_dispatch;

    localparam int BIAS_W = 16;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 12;

    logic                     system_clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     i_start = 1'b0;
    logic [CNT_W-1:0]         i_ch_num = '0;
    logic [CNT_W-1:0]         i_pix_num = '0;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_bias_rden;
    logic signed [BIAS_W-1:0] i_bias_data = '0;
    logic                     i_bias_empty = 1'b1;
    logic                     i_acc_valid = 1'b0;
    logic signed [ACC_W-1:0]  i_acc_data = '0;
    logic                     o_acc_ready;
    logic                     o_sum_valid;
    logic signed [OUT_W-1:0]  o_sum_data;
    logic                     i_sum_ready = 1'b0;

    bias_add_dispatch dut (
        .system_clk   (system_clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_ch_num     (i_ch_num),
        .i_pix_num    (i_pix_num),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_bias_rden  (o_bias_rden),
        .i_bias_data  (i_bias_data),
        .i_bias_empty (i_bias_empty),
        .i_acc_valid  (i_acc_valid),
        .i_acc_data   (i_acc_data),
        .o_acc_ready  (o_acc_ready),
        .o_sum_valid  (o_sum_valid),
        .o_sum_data   (o_sum_data),
        .i_sum_ready  (i_sum_ready)
    );

    always #5 system_clk = ~system_clk;

    int errors = 0;
    int checks = 0;

    // Environment state shared between the sequencer and the link agents.
    int fifo_q[$];
    int acc_q[$];
    int got_q[$];
    int acc_idx = 0;
    int pops = 0;
    int done_cnt = 0;
    int done_at_got = -1;
    int stab_viol = 0;
    int rden_viol = 0;
    int rdy_mode = 0;
    bit acc_gap = 1'b0;
    bit force_empty = 1'b0;
    int last_wait = 0;

    bit acc_hs_p = 1'b0;
    bit sum_hs_p = 1'b0;
    bit pop_p = 1'b0;
    bit stall_p = 1'b0;
    int sum_p = 0;
    int stall_data = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour of one biased sum, from plain integer arithmetic.
    function automatic int model(input int acc, input int bias);
        longint s;
        s = longint'(acc) + longint'(bias);
`ifdef BIAS_SAT_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return int'(s);
`else
        s = (s + 32768) % 65536;
        if (s < 0) s = s + 65536;
        return int'(s - 32768);
`endif
    endfunction

    // Agents: FIFO with one cycle read latency, accumulator source, sum sink.
    // Inputs change on the falling edge; the handshakes that the next rising
    // edge will perform are predicted 1 time unit later and committed on the
    // following falling edge.
    initial forever begin
        @(negedge system_clk);
        if (acc_hs_p) acc_idx++;
        if (sum_hs_p) got_q.push_back(sum_p);
        if (pop_p) begin
            pops++;
            if (fifo_q.size() > 0) i_bias_data = BIAS_W'(fifo_q.pop_front());
        end
        if (stall_p && (!o_sum_valid || (int'(o_sum_data) != stall_data))) stab_viol++;
        i_bias_empty = force_empty || (fifo_q.size() == 0);
        case (rdy_mode)
            0:       i_sum_ready = 1'b1;
            1:       i_sum_ready = !i_sum_ready;
            default: i_sum_ready = 1'($urandom_range(0, 1));
        endcase
        if ((acc_idx < acc_q.size()) && !(acc_gap && ($urandom_range(0, 3) == 0))) begin
            i_acc_valid = 1'b1;
            i_acc_data  = ACC_W'(acc_q[acc_idx]);
        end else begin
            i_acc_valid = 1'b0;
        end
        #1;
        acc_hs_p   = rst_n && i_acc_valid && o_acc_ready;
        sum_hs_p   = rst_n && o_sum_valid && i_sum_ready;
        sum_p      = int'(o_sum_data);
        pop_p      = o_bias_rden;
        stall_p    = rst_n && o_sum_valid && !i_sum_ready;
        stall_data = int'(o_sum_data);
        if (o_bias_rden && i_bias_empty) rden_viol++;
        if (o_done) begin
            if (done_cnt == 0) done_at_got = got_q.size();
            done_cnt++;
        end
    end

    task automatic wait_done(input int maxc, input string name);
        int n;
        n = 0;
        while ((done_cnt == 0) && (n < maxc)) begin
            @(negedge system_clk);
            #2;
            n++;
        end
        last_wait = n;
        check({name, "_done_seen"}, longint'(done_cnt > 0), 1);
    endtask

    // One complete layer pass checked against the reference model.
    task automatic run_pass(input int ch, input int pix, input int biases[$], input int accs[$],
                            input int rmode, input bit gap, input int hold_empty,
                            input bit extra_start, input string name);
        int exp_q[$];
        int rdy_hi;
        int exp_pops;
        exp_q.delete();
        for (int c = 0; c < ch; c++)
            for (int p = 0; p < pix; p++)
                exp_q.push_back(model(accs[c*pix+p], biases[c]));
        exp_pops = ((ch == 0) || (pix == 0)) ? 0 : ch;
        @(negedge system_clk);
        #2;
        fifo_q = biases;
        acc_q = accs;
        acc_idx = 0;
        got_q.delete();
        pops = 0;
        done_cnt = 0;
        done_at_got = -1;
        stab_viol = 0;
        rdy_mode = rmode;
        acc_gap = gap;
        force_empty = (hold_empty > 0);
        @(negedge system_clk);
        i_start = 1'b1;
        i_ch_num = CNT_W'(ch);
        i_pix_num = CNT_W'(pix);
        @(negedge system_clk);
        i_start = 1'b0;
        if (extra_start) begin
            @(negedge system_clk);
            i_start = 1'b1;
            i_ch_num = '0;
            i_pix_num = CNT_W'(3);
            @(negedge system_clk);
            i_start = 1'b0;
        end
        if (hold_empty > 0) begin
            rdy_hi = 0;
            for (int k = 0; k < hold_empty; k++) begin
                @(negedge system_clk);
                #2;
                if (o_acc_ready) rdy_hi++;
            end
            check({name, "_pops_while_empty"}, pops, 0);
            check({name, "_acc_ready_while_empty"}, rdy_hi, 0);
            check({name, "_acc_taken_while_empty"}, acc_idx, 0);
            force_empty = 1'b0;
        end
        wait_done(ch * pix * 6 + 40, name);
        repeat (3) begin
            @(negedge system_clk);
            #2;
        end
        check({name, "_sum_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_sum%0d", name, i), got_q[i], exp_q[i]);
        check({name, "_pops"}, pops, exp_pops);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_sums_before_done"}, done_at_got, exp_q.size());
        check({name, "_stall_stability"}, stab_viol, 0);
        check({name, "_busy_after"}, o_busy, 0);
        if ((ch == 0) || (pix == 0)) check({name, "_zero_done_latency_ok"}, longint'(last_wait <= 2), 1);
    endtask

    typedef struct {
        int acc;
        int bias;
        int exp_sat;
        int exp_wrap;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int b[$];
        int a[$];
        int n;
        int exp_v;

        tbl[0] = '{acc: 32767,   bias: 100,    exp_sat: 32767,  exp_wrap: -32669};
        tbl[1] = '{acc: -32768,  bias: -1,     exp_sat: -32768, exp_wrap: 32767};
        tbl[2] = '{acc: 10,      bias: 5,      exp_sat: 15,     exp_wrap: 15};
        tbl[3] = '{acc: -20,     bias: -7,     exp_sat: -27,    exp_wrap: -27};
        tbl[4] = '{acc: 524287,  bias: 0,      exp_sat: 32767,  exp_wrap: -1};
        tbl[5] = '{acc: -524288, bias: -1,     exp_sat: -32768, exp_wrap: -1};
        tbl[6] = '{acc: -32768,  bias: -32768, exp_sat: -32768, exp_wrap: 0};

        // Reset with start held high: nothing may happen.
        rst_n = 1'b0;
        i_start = 1'b1;
        i_ch_num = CNT_W'(2);
        i_pix_num = CNT_W'(2);
        fifo_q = {1, 2};
        repeat (3) @(negedge system_clk);
        #2;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_rden", o_bias_rden, 0);
        check("rst_acc_ready", o_acc_ready, 0);
        check("rst_sum_valid", o_sum_valid, 0);
        check("rst_sum_data", o_sum_data, 0);
        @(negedge system_clk);
        rst_n = 1'b1;
        i_start = 1'b0;
        repeat (5) @(negedge system_clk);
        #2;
        check("rst_release_busy", o_busy, 0);
        check("rst_pops", pops, 0);
        fifo_q.delete();

        // Table of single-sum passes covering wrap/saturation corners.
        for (int i = 0; i < 7; i++) begin
            b = {tbl[i].bias};
            a = {tbl[i].acc};
            run_pass(1, 1, b, a, 0, 1'b0, 0, 1'b0, $sformatf("tbl%0d", i));
`ifdef BIAS_SAT_EN
            exp_v = tbl[i].exp_sat;
`else
            exp_v = tbl[i].exp_wrap;
`endif
            check($sformatf("tbl%0d_value", i), (got_q.size() > 0) ? got_q[0] : 99999, exp_v);
        end

        // Basic two-channel pass.
        b = {5, -7};
        a = {10, 20, 30, 1, 2, 3};
        run_pass(2, 3, b, a, 0, 1'b0, 0, 1'b0, "basic");

        // Empty FIFO held after start.
        b = {-3};
        a = {100, 200};
        run_pass(1, 2, b, a, 0, 1'b0, 10, 1'b0, "empty");

        // Alternating downstream ready, with a start pulse while busy.
        b = {1000};
        a = {1, -2, 3, -4};
        run_pass(1, 4, b, a, 1, 1'b0, 0, 1'b1, "bkpr");

        // Zero-size configurations.
        b.delete();
        a.delete();
        run_pass(0, 3, b, a, 0, 1'b0, 0, 1'b0, "zero_ch");
        run_pass(2, 0, b, a, 0, 1'b0, 0, 1'b0, "zero_pix");

        // Randomized passes with random stalls on both links.
        for (int r = 0; r < 6; r++) begin
            int ch;
            int pix;
            ch = int'($urandom_range(1, 3));
            pix = int'($urandom_range(1, 5));
            b.delete();
            a.delete();
            for (int c = 0; c < ch; c++) b.push_back(int'($urandom_range(0, 65535)) - 32768);
            for (int k = 0; k < ch * pix; k++) a.push_back(int'($urandom_range(0, 1048575)) - 524288);
            run_pass(ch, pix, b, a, 2, 1'b1, 0, 1'b0, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a pass.
        @(negedge system_clk);
        #2;
        fifo_q = {11, 22};
        acc_q = {1, 2, 3, 4, 5, 6, 7, 8};
        acc_idx = 0;
        got_q.delete();
        pops = 0;
        done_cnt = 0;
        rdy_mode = 0;
        acc_gap = 1'b0;
        @(negedge system_clk);
        i_start = 1'b1;
        i_ch_num = CNT_W'(2);
        i_pix_num = CNT_W'(4);
        @(negedge system_clk);
        i_start = 1'b0;
        n = 0;
        while ((acc_idx < 2) && (n < 50)) begin
            @(negedge system_clk);
            #2;
            n++;
        end
        check("midrst_reached_run", longint'(acc_idx >= 2), 1);
        @(negedge system_clk);
        rst_n = 1'b0;
        @(negedge system_clk);
        rst_n = 1'b1;
        #2;
        acc_q.delete();
        check("midrst_busy", o_busy, 0);
        check("midrst_sum_valid", o_sum_valid, 0);
        check("midrst_sum_data", o_sum_data, 0);
        check("midrst_acc_ready", o_acc_ready, 0);
        check("midrst_rden", o_bias_rden, 0);
        repeat (10) @(negedge system_clk);
        #2;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_pops", pops, 1);
        check("midrst_fifo_left", fifo_q.size(), 1);
        check("midrst_busy_idle", o_busy, 0);

        check("rden_never_when_empty", rden_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
